// File: rtl/axi_capture_pkg.sv
// -----------------------------------------------------------------------------
// axi_capture_pkg
// Shared types and helpers for the stream capture block.
//   capture_state_t : FSM state encoding (IDLE, CAPTURE, DONE)
//   clamp_length()  : limits a requested beat count to the buffer depth
// -----------------------------------------------------------------------------
package axi_capture_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } capture_state_t;

   // A request longer than the buffer is cut down to the buffer size, which is
   // what keeps the write pointer from ever wrapping.
   function automatic int unsigned clamp_length(input int unsigned len,
                                                input int unsigned depth);
      return (len > depth) ? depth : len;
   endfunction

endpackage

// File: rtl/axi_pipeline_connect.sv
// -----------------------------------------------------------------------------
// axiPipelineConnect
// Valid/ready stream bundle used between pipeline stages.
//   data  : payload, WIDTH bits, driven by the producer
//   valid : producer has a beat on data
//   ready : consumer will take the beat this cycle
// Modports:
//   pipeline  : consumer side (data/valid in, ready out)
//   producer  : producer side (data/valid out, ready in)
// -----------------------------------------------------------------------------
interface axiPipelineConnect #(
   parameter int unsigned WIDTH = 32
);
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             ready;

   modport pipeline (input data, input valid, output ready);
   modport producer (output data, output valid, input ready);
endinterface

// File: rtl/capture_ram.sv
// -----------------------------------------------------------------------------
// capture_ram
// Simple dual-port buffer: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
// The storage array itself is never reset; only the read register is.
//   clk      : clock
//   reset    : synchronous active-high reset (clears the read register)
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : word at i_raddr, one cycle later
// -----------------------------------------------------------------------------
module capture_ram
   import axi_capture_pkg::*;
#(
   parameter  int unsigned WIDTH  = 32,
   parameter  int unsigned DEPTH  = 256,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [WIDTH-1:0]  i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [WIDTH-1:0]  o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Non-blocking read in the same edge as the write yields the pre-write word.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_stream_capture.sv
// -----------------------------------------------------------------------------
// axi_stream_capture
// Terminating sink of a valid/ready stream. After an accepted start it stores
// up to `length` beats (clamped to DEPTH) into an internal buffer from address
// 0, then reports completion. A registered read port exposes the buffer.
//   clk      : clock (rising edge)
//   reset    : synchronous active-high reset
//   source   : input stream (data/valid in, ready out)
//   start    : pulse, arms a capture when idle or done
//   length   : beats to capture, sampled with an accepted start
//   abort    : ends an active capture early
//   busy     : capture in progress
//   done     : capture finished, held until the next accepted start
//   count    : beats stored in the current or last capture
//   rd_addr  : buffer read address
//   rd_data  : buffer word at rd_addr, one cycle later
// -----------------------------------------------------------------------------
module axi_stream_capture
   import axi_capture_pkg::*;
#(
   parameter  int unsigned WIDTH  = 32,
   parameter  int unsigned DEPTH  = 256,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   axiPipelineConnect.pipeline source,
   input  logic                start,
   input  logic [ADDR_W:0]     length,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W:0]     count,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [WIDTH-1:0]    rd_data
);

   localparam int unsigned      CNT_W   = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   capture_state_t    r_state;
   capture_state_t    w_state_next;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  r_len;
   logic [CNT_W-1:0]  w_len_clamped;
   logic              w_ready;
   logic              w_accept;
   logic              w_start_ok;
   logic              w_wr_en;
   logic [ADDR_W-1:0] w_wr_addr;

   assign w_len_clamped = CNT_W'(clamp_length(32'(length), DEPTH));

   // Start is only honoured outside an active capture.
   assign w_start_ok = start && (r_state != CAPTURE);

   // Accept depends on the state register and valid only; ready itself never
   // looks at valid.
   assign w_accept = (r_state == CAPTURE) && source.valid;

   // Count and write pointer advance together from 0, so the low bits of the
   // count are the write address. The clamp keeps the address in range.
   assign w_wr_addr = r_count[ADDR_W-1:0];

   // A beat presented during the reset cycle is not stored.
   assign w_wr_en = w_accept && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            done = (r_state == DONE);
            if (start) begin
               w_state_next = (w_len_clamped == '0) ? DONE : CAPTURE;
            end
         end
         CAPTURE: begin
            w_ready = 1'b1;
            busy    = 1'b1;
            // An abort coinciding with an accept still lets that beat land.
            if (abort || (w_accept && ((r_count + CNT_ONE) == r_len))) begin
               w_state_next = DONE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
         r_len   <= '0;
      end else if (w_start_ok) begin
         r_count <= '0;
         r_len   <= w_len_clamped;
      end else if (w_accept) begin
         r_count <= r_count + CNT_ONE;
      end
   end

   assign source.ready = w_ready;
   assign count        = r_count;

   capture_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_wr_en),
      .i_waddr (w_wr_addr),
      .i_wdata (source.data),
      .i_raddr (rd_addr),
      .o_rdata (rd_data)
   );

endmodule

// File: doc/axi_stream_capture.md
# axi_stream_capture

Sink endpoint for the valid/ready pipeline interface: consumes beats from an `axiPipelineConnect` stream and stores them in an internal buffer. It captures a programmed number of beats, then signals completion. A registered random-access read port lets control logic or a debug bus read the captured words. It is the terminating consumer at the downstream end of an `axiPipeline` chain.

## Interface
- `WIDTH`, 32, data width of the stream and of buffer words.
- `DEPTH`, 256, buffer depth in words; power of two, ≥ 2.
- `ADDR_W`, derived `$clog2(DEPTH)`, not overridden.

- `clk`  input  1  sole clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `source`  `axiPipelineConnect.pipeline`  WIDTH+2  input stream (`data`, `valid` in; `ready` out).
- `start`  input  1  single-cycle pulse; arms a capture.
- `length`  input  ADDR_W+1  beats to capture, sampled on accepted `start`.
- `abort`  input  1  ends an active capture early.
- `busy`  output  1  high while capturing.
- `done`  output  1  high from capture end until the next accepted `start`.
- `count`  output  ADDR_W+1  beats stored in the current or last capture.
- `rd_addr`  input  ADDR_W  buffer read address.
- `rd_data`  output  WIDTH  buffer word at `rd_addr`, one cycle later.

## Operation
- FSM states: IDLE, CAPTURE, DONE.
- IDLE + `start`: latch `length` into `len_q`, clamped to DEPTH; clear `count` and write pointer. If `len_q == 0`, go to DONE, otherwise go to CAPTURE.
- CAPTURE:
  - `source.ready = 1`, decoded from the state register only; there is no combinational path from `source.valid`.
  - Accept when `valid && ready`: `mem[wr_ptr] <= data`, then increment `wr_ptr` and `count`.
  - Accept with `count + 1 == len_q`: go to DONE.
- CAPTURE + `abort`: go to DONE.
  - An accept in the same cycle is still stored and counted.
  - `abort` in IDLE or DONE is ignored.
- CAPTURE + `start`: ignored.
- DONE + `start`: re-arm exactly as from IDLE. The buffer is overwritten from address 0.
- Write pointer never wraps: at most DEPTH beats are stored, guaranteed by the clamp.
- Read port:
  - `rd_data <= mem[rd_addr]` every cycle, in all states.
  - Same-address read and write in one cycle returns the old word (read-before-write).
- Outputs are a function of the state only: `busy` = CAPTURE, `done` = DONE.
- Reset: state IDLE, `source.ready` 0, `busy` 0, `done` 0, `count` 0, `rd_data` 0. Buffer contents are not reset.
- Reset mid-capture: returns to IDLE next edge; no `done` is asserted.

## Timing
- `start` at edge N: `busy` and `ready` are high from cycle N+1.
- Sustained throughput: 1 beat/cycle while CAPTURE and `valid` are both high.
- Last accept at edge M: `ready` low and `done` high from cycle M+1, `count == len_q`.
- `count` updates on the edge after each accept.
- Read latency: exactly 1 cycle.
- `length == 0` start at edge N: `done` high at N+1, `busy` never asserts.

## Structure
- Package `axi_capture_pkg` holds:
  - `capture_state_t` enum (IDLE, CAPTURE, DONE).
  - Helper function for the `length` clamp.
- Sub-module `capture_ram`: simple dual-port RAM with one write port, one registered read port, read-before-write, and no reset on the array.
- Top level holds the FSM, pointer/count registers and the `ready` decode.

## Test plan
- `length=4`, continuous valid, data 0xA0..0xA3 → `ready` high for exactly 4 cycles, `done` at +1, `count=4`, reads at addr 0..3 return 0xA0..0xA3.
- `length=3`, valid toggled 1-0-1-0-1 → 3 beats stored in order, no duplicates, `done` after the 3rd accept.
- `abort` in the same cycle as the 2nd accept of `length=8` → `count=2`, `done=1`, `ready=0` next cycle.
- `length=DEPTH+5` with DEPTH=8 → exactly 8 beats captured, `count=8`.
- `start` with `length=0` → `done` next cycle, `count=0`, `ready` never high.
- `reset` asserted mid-capture, then a new `start` with `length=2` → all outputs at reset values, then a clean 2-beat capture.
